vc_credit_returner: RTL and testbench
=====================================

// Module: vc_credit_returner
// PURPOSE
//  Receive-side credit bookkeeping for one switch input port. Tracks per-VC input buffer
//  occupancy and credits owed to the upstream link partner, then returns them one at a time
//  over the credit channel. Feeds the upstream VC allocator's credit_granted input.
//  Sits between link RX deserialiser, input VC buffers and the link TX credit path.
// PARAMETERS
//  NUM_VCS       2  virtual channels per link (same across links)
//  BUFFER_DEPTH  8  flit slots per VC in the input buffer = credits upstream starts with
// PORTS
//  clk            in   1                 clock
//  rst            in   1                 synchronous active-high reset
//  flit_valid_in  in   1                 flit written into input buffer this cycle
//  flit_vc_in     in   $clog2(NUM_VCS)   VC of incoming flit
//  flit_dequeue   in   NUM_VCS           per-VC: flit left the buffer (forwarded by switch)
//  credit_valid   out  1                 credit offered to link TX
//  credit_vc      out  $clog2(NUM_VCS)   VC the offered credit belongs to
//  credit_ready   in   1                 link TX accepts credit (valid&&ready = transfer)
//  occupancy      out  NUM_VCS x $clog2(BUFFER_DEPTH+1)  flits resident per VC
//  err_overflow   out  1                 sticky: flit arrived with no slot owed (CREDIT_CHECK_EN)
//  err_underflow  out  1                 sticky: dequeue from empty VC (CREDIT_CHECK_EN)
// BEHAVIOUR
//  Reset: occupancy=0, pending=0, credit_valid=0, credit_vc=0, rr_ptr=NUM_VCS-1, FSM=IDLE,
//   err_*=0. Upstream holds BUFFER_DEPTH credits per VC; nothing is sent at reset.
//  occupancy[v]: +1 on flit_valid_in&&flit_vc_in==v; -1 on flit_dequeue[v]; both -> hold.
//  pending[v] (internal, same width): +1 on flit_dequeue[v]; -1 on transfer with credit_vc==v;
//   both same cycle -> hold. Invariant occupancy[v]+pending[v] <= BUFFER_DEPTH.
//  Multiple VCs may dequeue in one cycle; each counter updates independently.
//  FSM IDLE: if any pending>0, select VC round-robin starting at rr_ptr+1 (wrap to 0 after
//   NUM_VCS-1), register credit_vc, go SEND. Latency dequeue(t) -> credit_valid(t+1).
//  FSM SEND: credit_valid=1, credit_vc stable until transfer. On transfer: rr_ptr<=credit_vc;
//   re-select using post-decrement pending (same VC eligible only if pending still >0 and no
//   other VC pending); if a candidate exists reload credit_vc and stay SEND (back-to-back,
//   1 credit/cycle), else credit_valid<=0, go IDLE.
//  A dequeue in the transfer cycle is visible to selection the following cycle only.
//  rst mid-SEND: credit_valid drops next edge; owed credits are discarded (link resets too).
// CONFIGURATION
//  CREDIT_CHECK_EN defined: arrival on v with occupancy[v]+pending[v]==BUFFER_DEPTH sets
//   err_overflow, occupancy[v] saturates (no increment); flit_dequeue[v] with occupancy[v]==0
//   sets err_underflow, no occupancy decrement, no pending increment. Flags clear only on rst.
//  Not defined: err_overflow=err_underflow=0 constant; no guards, counters wrap modulo width.
// STRUCTURE
//  Shared package switch_pkg: vc_t (logic [$clog2(NUM_VCS)-1:0]), credit_cnt_t, typedef enum
//   credit_state_t {CR_IDLE, CR_SEND}.
//  One sub-module: vc_rr_select (pending-nonzero mask + rr_ptr -> grant_valid, grant_vc),
//   purely combinational, reused by VC allocator.
// TESTING
//  1 Reset then idle 10 cycles -> credit_valid=0, occupancy all 0, err_* 0.
//  2 NUM_VCS=2: 3 flits VC1, dequeue 1 at cycle t, credit_ready=1 -> credit_valid=1,
//    credit_vc=1 at t+1 only; occupancy[1]=2.
//  3 Dequeue VC0 and VC1 same cycle, ready=1 -> credits VC0 then VC1 on consecutive cycles,
//    next round starts at VC0 (rr fairness), no bubble.
//  4 credit_ready=0 for 5 cycles with pending on both VCs -> credit_vc frozen, no counter loss;
//    release ready -> exactly 2 transfers total.
//  5 CREDIT_CHECK_EN: 9 flits into VC0 (DEPTH 8) -> err_overflow=1, occupancy[0]=8;
//    dequeue empty VC1 -> err_underflow=1, no credit emitted.
//  6 Assert rst while credit_valid=1 -> next cycle credit_valid=0, all counters 0.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch definitions: default link geometry, VC index / credit counter
// types, the credit-return FSM state type and an index-width helper.
package switch_pkg;

  localparam int unsigned SW_NUM_VCS      = 2;
  localparam int unsigned SW_BUFFER_DEPTH = 8;
  localparam int unsigned SW_VC_W         = (SW_NUM_VCS > 1) ? $clog2(SW_NUM_VCS) : 1;
  localparam int unsigned SW_CNT_W        = $clog2(SW_BUFFER_DEPTH + 1);

  typedef logic [SW_VC_W-1:0]  vc_t;
  typedef logic [SW_CNT_W-1:0] credit_cnt_t;

  typedef enum logic {
    CR_IDLE,
    CR_SEND
  } credit_state_t;

  // Width of an index over n items; a single item still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vc_credit_returner_if.sv
// Bundle for vc_credit_returner: flit arrival/dequeue notifications in,
// credit channel (valid/vc/ready) out, per-VC occupancy and error flags out.
//   master : environment side (drives flit_*, credit_ready)
//   slave  : credit returner side (drives credit_valid/vc, occupancy, err_*)
interface vc_credit_returner_if
  import switch_pkg::*;
#(
  parameter int unsigned NUM_VCS      = SW_NUM_VCS,
  parameter int unsigned BUFFER_DEPTH = SW_BUFFER_DEPTH
);
  localparam int unsigned VW = idx_width(NUM_VCS);
  localparam int unsigned CW = $clog2(BUFFER_DEPTH + 1);

  logic                        flit_valid_in;
  logic [VW-1:0]               flit_vc_in;
  logic [NUM_VCS-1:0]          flit_dequeue;
  logic                        credit_valid;
  logic [VW-1:0]               credit_vc;
  logic                        credit_ready;
  logic [NUM_VCS-1:0][CW-1:0]  occupancy;
  logic                        err_overflow;
  logic                        err_underflow;

  modport master (
    output flit_valid_in, flit_vc_in, flit_dequeue, credit_ready,
    input  credit_valid, credit_vc, occupancy, err_overflow, err_underflow
  );

  modport slave (
    input  flit_valid_in, flit_vc_in, flit_dequeue, credit_ready,
    output credit_valid, credit_vc, occupancy, err_overflow, err_underflow
  );

endinterface

// File: rtl/vc_rr_select.sv
// Combinational round-robin VC picker.
//   i_mask        : per-VC request (e.g. pending credits nonzero)
//   i_rr_ptr      : last granted VC; search begins at i_rr_ptr+1 and wraps
//   o_grant_valid : any request present
//   o_grant_vc    : chosen VC
module vc_rr_select #(
  parameter int unsigned NUM_VCS = 2,
  parameter int unsigned VW      = 1
) (
  input  logic [NUM_VCS-1:0] i_mask,
  input  logic [VW-1:0]      i_rr_ptr,
  output logic               o_grant_valid,
  output logic [VW-1:0]      o_grant_vc
);

  int unsigned w_dist;
  int unsigned w_best;

  // Pick the requester with the smallest forward distance from rr_ptr+1.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_vc    = '0;
    w_best        = NUM_VCS;
    w_dist        = 0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      w_dist = (v + NUM_VCS - 1 - 32'(i_rr_ptr)) % NUM_VCS;
      if (i_mask[v] && (w_dist < w_best)) begin
        w_best        = w_dist;
        o_grant_valid = 1'b1;
        o_grant_vc    = VW'(v);
      end
    end
  end

endmodule

// File: rtl/vc_credit_returner.sv
// Receive-side credit bookkeeping for one switch input port.
// Tracks per-VC buffer occupancy and credits owed upstream, returning owed
// credits one per cycle, round-robin across VCs, over the credit channel.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   cr_if    : vc_credit_returner_if.slave (flit arrival/dequeue in,
//              credit_valid/credit_vc/credit_ready, occupancy, err_* out)
// Build option: define CREDIT_CHECK_EN to enable overflow/underflow guards
// and sticky error flags; otherwise flags are 0 and counters wrap.
module vc_credit_returner
  import switch_pkg::*;
#(
  parameter int unsigned NUM_VCS      = SW_NUM_VCS,
  parameter int unsigned BUFFER_DEPTH = SW_BUFFER_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  vc_credit_returner_if.slave cr_if
);

  localparam int unsigned VW = idx_width(NUM_VCS);
  localparam int unsigned CW = $clog2(BUFFER_DEPTH + 1);

  credit_state_t              r_state;
  credit_state_t              w_state_nxt;
  logic [NUM_VCS-1:0][CW-1:0] r_occ;
  logic [NUM_VCS-1:0][CW-1:0] r_pend;
  logic [VW-1:0]              r_credit_vc;
  logic [VW-1:0]              r_rr_ptr;
  logic                       r_err_ovf;
  logic                       r_err_unf;

  logic [NUM_VCS-1:0]         w_arrive;
  logic [NUM_VCS-1:0]         w_ovf;
  logic [NUM_VCS-1:0]         w_unf;
  logic [NUM_VCS-1:0]         w_inc_occ;
  logic [NUM_VCS-1:0]         w_deq;
  logic [NUM_VCS-1:0]         w_dec_pend;
  logic [NUM_VCS-1:0]         w_sel_mask;
  logic [VW-1:0]              w_sel_ptr;
  logic                       w_xfer;
  logic                       w_grant_valid;
  logic [VW-1:0]              w_grant_vc;

  assign w_xfer = (r_state == CR_SEND) && cr_if.credit_ready;

  always_comb begin
    w_arrive   = '0;
    w_ovf      = '0;
    w_unf      = '0;
    w_dec_pend = '0;
    w_sel_mask = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      w_arrive[v]   = cr_if.flit_valid_in && (cr_if.flit_vc_in == VW'(v));
      w_dec_pend[v] = w_xfer && (r_credit_vc == VW'(v));
`ifdef CREDIT_CHECK_EN
      w_ovf[v] = w_arrive[v] &&
                 (({1'b0, r_occ[v]} + {1'b0, r_pend[v]}) == (CW+1)'(BUFFER_DEPTH));
      w_unf[v] = cr_if.flit_dequeue[v] && (r_occ[v] == '0);
`endif
    end
    w_inc_occ = w_arrive & ~w_ovf;
    w_deq     = cr_if.flit_dequeue & ~w_unf;
    // IDLE sees this cycle's dequeues (one-cycle credit latency); on a transfer
    // the mask is post-decrement pending only, so a dequeue landing in the
    // transfer cycle competes from the next cycle on.
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      if (r_state == CR_SEND)
        w_sel_mask[v] = (r_pend[v] - CW'(w_dec_pend[v])) != '0;
      else
        w_sel_mask[v] = (r_pend[v] != '0) || w_deq[v];
    end
  end

  assign w_sel_ptr = (r_state == CR_SEND) ? r_credit_vc : r_rr_ptr;

  vc_rr_select #(
    .NUM_VCS (NUM_VCS),
    .VW      (VW)
  ) u_rr_select (
    .i_mask        (w_sel_mask),
    .i_rr_ptr      (w_sel_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_vc    (w_grant_vc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= CR_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CR_IDLE: if (w_grant_valid)            w_state_nxt = CR_SEND;
      CR_SEND: if (w_xfer && !w_grant_valid) w_state_nxt = CR_IDLE;
      default:                               w_state_nxt = CR_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cr_if.credit_valid = (r_state == CR_SEND);
    cr_if.credit_vc    = r_credit_vc;
    cr_if.occupancy    = r_occ;
`ifdef CREDIT_CHECK_EN
    cr_if.err_overflow  = r_err_ovf;
    cr_if.err_underflow = r_err_unf;
`else
    cr_if.err_overflow  = 1'b0;
    cr_if.err_underflow = 1'b0;
`endif
  end

  // Offered VC and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit_vc <= '0;
      r_rr_ptr    <= VW'(NUM_VCS - 1);
    end else begin
      if (w_xfer) r_rr_ptr <= r_credit_vc;
      if (((r_state == CR_IDLE) || w_xfer) && w_grant_valid)
        r_credit_vc <= w_grant_vc;
    end
  end

  // Per-VC occupancy and owed-credit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ  <= '0;
      r_pend <= '0;
    end else begin
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        case ({w_inc_occ[v], w_deq[v]})
          2'b10:   r_occ[v] <= r_occ[v] + CW'(1);
          2'b01:   r_occ[v] <= r_occ[v] - CW'(1);
          default: r_occ[v] <= r_occ[v];
        endcase
        case ({w_deq[v], w_dec_pend[v]})
          2'b10:   r_pend[v] <= r_pend[v] + CW'(1);
          2'b01:   r_pend[v] <= r_pend[v] - CW'(1);
          default: r_pend[v] <= r_pend[v];
        endcase
      end
    end
  end

`ifdef CREDIT_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      r_err_ovf <= r_err_ovf | (|w_ovf);
      r_err_unf <= r_err_unf | (|w_unf);
    end
  end
`else
  always_ff @(posedge clk) begin
    r_err_ovf <= 1'b0;
    r_err_unf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_vc_credit_returner.sv
module tb_vc_credit_returner;

  localparam int NV    = 2;
  localparam int DEPTH = 8;
  localparam int MODC  = 16;  // counter modulus for 4-bit counters

  logic clk;
  logic rst;

  vc_credit_returner_if #(.NUM_VCS(NV), .BUFFER_DEPTH(DEPTH)) bus();

  vc_credit_returner #(.NUM_VCS(NV), .BUFFER_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .cr_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int n_xfer;

  // Reference model: counts per VC plus "is a credit being offered, for which VC"
  int m_occ [NV];
  int m_pend[NV];
  bit m_off;
  int m_vc;
  int m_last;
  bit m_eo;
  bit m_eu;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int x);
    return ((x % MODC) + MODC) % MODC;
  endfunction

  // First requester after 'start' going upward and wrapping; -1 if none.
  function automatic int pick(input int start, input bit req[NV]);
    int r;
    r = -1;
    for (int k = NV; k >= 1; k--)
      if (req[(start + k) % NV]) r = (start + k) % NV;
    return r;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_occ[v]  = 0;
      m_pend[v] = 0;
    end
    m_off  = 0;
    m_vc   = 0;
    m_last = NV - 1;
    m_eo   = 0;
    m_eu   = 0;
  endtask

  task automatic model_step(input bit fv, input int fvc, input bit [NV-1:0] deq, input bit rdy);
    bit xfer;
    bit arr [NV];
    bit d   [NV];
    int pa  [NV];
    bit req [NV];
    int c;
    xfer = m_off && rdy;
    for (int v = 0; v < NV; v++) begin
      arr[v] = fv && (fvc == v);
      d[v]   = deq[v];
`ifdef CREDIT_CHECK_EN
      if (arr[v] && (m_occ[v] + m_pend[v] == DEPTH)) begin m_eo = 1; arr[v] = 0; end
      if (d[v] && (m_occ[v] == 0)) begin m_eu = 1; d[v] = 0; end
`endif
      pa[v] = wrap(m_pend[v] - ((xfer && m_vc == v) ? 1 : 0));
    end
    if (!m_off) begin
      for (int v = 0; v < NV; v++) req[v] = (m_pend[v] != 0) || d[v];
      c = pick(m_last, req);
      if (c >= 0) begin m_off = 1; m_vc = c; end
    end else if (xfer) begin
      m_last = m_vc;
      for (int v = 0; v < NV; v++) req[v] = (pa[v] != 0);
      c = pick(m_vc, req);
      if (c >= 0) m_vc = c;
      else        m_off = 0;
    end
    for (int v = 0; v < NV; v++) begin
      m_occ[v]  = wrap(m_occ[v] + (arr[v] ? 1 : 0) - (d[v] ? 1 : 0));
      m_pend[v] = wrap(pa[v] + (d[v] ? 1 : 0));
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(bus.credit_valid), 32'(m_off));
    if (m_off) check({tag, ".vc"}, 32'(bus.credit_vc), 32'(m_vc));
    for (int v = 0; v < NV; v++)
      check($sformatf("%s.occ%0d", tag, v), 32'(bus.occupancy[v]), 32'(m_occ[v]));
    check({tag, ".eo"}, 32'(bus.err_overflow),  32'(m_eo));
    check({tag, ".eu"}, 32'(bus.err_underflow), 32'(m_eu));
  endtask

  // One clock: drive inputs, advance model, sample #1 after the edge.
  task automatic cycle(input bit fv, input int fvc, input bit [NV-1:0] deq,
                       input bit rdy, input bit rst_in, input string tag);
    rst                = rst_in;
    bus.flit_valid_in  = fv;
    bus.flit_vc_in     = 1'(fvc);
    bus.flit_dequeue   = deq;
    bus.credit_ready   = rdy;
    if (bus.credit_valid && rdy && !rst_in) n_xfer++;
    if (rst_in) model_reset();
    else        model_step(fv, fvc, deq, rdy);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_xfer = 0;
    model_reset();
    rst = 1'b1;
    bus.flit_valid_in = 1'b0;
    bus.flit_vc_in    = '0;
    bus.flit_dequeue  = '0;
    bus.credit_ready  = 1'b0;

    // 1: reset, then idle
    cycle(0, 0, 2'b00, 0, 1, "rst");
    cycle(0, 0, 2'b00, 0, 1, "rst");
    check("rst.vc0", 32'(bus.credit_vc), 32'd0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 2'b00, 0, 0, "idle");

    // 2: three flits on VC1, dequeue one -> credit on VC1 for exactly one cycle
    for (int i = 0; i < 3; i++) cycle(1, 1, 2'b00, 1, 0, "fill1");
    cycle(0, 0, 2'b10, 1, 0, "deq1");
    check("t2.valid", 32'(bus.credit_valid), 32'd1);
    check("t2.vc", 32'(bus.credit_vc), 32'd1);
    check("t2.occ1", 32'(bus.occupancy[1]), 32'd2);
    cycle(0, 0, 2'b00, 1, 0, "t2.after");
    check("t2.drop", 32'(bus.credit_valid), 32'd0);

    // 3: simultaneous dequeue on both VCs, back-to-back credits, fair restart
    cycle(1, 0, 2'b00, 1, 0, "fill0");
    cycle(1, 0, 2'b00, 1, 0, "fill0");
    cycle(0, 0, 2'b11, 1, 0, "t3.deq");
    check("t3.first", 32'(bus.credit_vc), 32'd0);
    cycle(0, 0, 2'b00, 1, 0, "t3.b2b");
    check("t3.second_valid", 32'(bus.credit_valid), 32'd1);
    check("t3.second", 32'(bus.credit_vc), 32'd1);
    cycle(0, 0, 2'b00, 1, 0, "t3.idle");
    cycle(0, 0, 2'b11, 1, 0, "t3.deq2");
    check("t3.round2", 32'(bus.credit_vc), 32'd0);
    cycle(0, 0, 2'b00, 1, 0, "t3.r2b");
    cycle(0, 0, 2'b00, 1, 0, "t3.r2c");

    // 4: backpressure on the credit channel
    cycle(1, 0, 2'b00, 1, 0, "fill");
    cycle(1, 1, 2'b00, 1, 0, "fill");
    n_xfer = 0;
    cycle(0, 0, 2'b11, 0, 0, "t4.deq");
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 2'b00, 0, 0, "t4.hold");
      check("t4.frozen", 32'(bus.credit_vc), 32'd0);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 2'b00, 1, 0, "t4.rel");
    check("t4.xfers", 32'(n_xfer), 32'd2);

`ifdef CREDIT_CHECK_EN
    // 5: overflow and underflow guards
    cycle(0, 0, 2'b00, 1, 1, "t5.rst");
    for (int i = 0; i < 9; i++) cycle(1, 0, 2'b00, 1, 0, "t5.fill");
    check("t5.eo", 32'(bus.err_overflow), 32'd1);
    check("t5.occ0", 32'(bus.occupancy[0]), 32'd8);
    cycle(0, 0, 2'b10, 1, 0, "t5.unf");
    check("t5.eu", 32'(bus.err_underflow), 32'd1);
    check("t5.nocred", 32'(bus.credit_valid), 32'd0);
    cycle(0, 0, 2'b00, 1, 1, "t5.rst2");
`endif

    // Randomized legal traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bit fv;
      int fvc;
      bit [NV-1:0] deq;
      bit rdy;
      fvc = int'($urandom_range(NV - 1));
      fv  = ($urandom_range(99) < 50) && (m_occ[fvc] + m_pend[fvc] < DEPTH);
      for (int v = 0; v < NV; v++)
        deq[v] = ($urandom_range(99) < 40) && (m_occ[v] > 0);
      rdy = ($urandom_range(99) < 70);
      cycle(fv, fvc, deq, rdy, 0, "rand");
    end

    // 6: reset while a credit is offered
    cycle(1, 0, 2'b00, 0, 0, "t6.fill");
    cycle(0, 0, 2'b01, 0, 0, "t6.deq");
    check("t6.pre", 32'(bus.credit_valid), 32'd1);
    cycle(0, 0, 2'b00, 1, 1, "t6.rst");
    check("t6.valid", 32'(bus.credit_valid), 32'd0);
    check("t6.occ0", 32'(bus.occupancy[0]), 32'd0);
    cycle(0, 0, 2'b00, 1, 0, "t6.post");
    cycle(0, 0, 2'b00, 1, 0, "t6.post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
